// File: rtl/m3_stepperiodmeasure.sv
// rtl/m3_stepperiodmeasure.sv - commutation step period / round period / direction monitor
//
// Watches the 4-bit step index from the motor step generator (0..11 = one
// electrical round, 15 = idle). It measures clocks per step and per 12-step
// round, works out the rotation direction, and flags stall, over-speed and
// illegal step sequences.
//
// Ports:
//   clkI         1 MHz clock
//   nRstI        asynchronous active-low reset
//   stepI        step index from the generator (0..11 valid, 15 idle)
//   clrErrI      clears the sticky seqErrO
//   stepPeriodO  last measured step length in clocks
//   stepValidO   one-cycle pulse when stepPeriodO updates
//   roundPeriodO last measured 12-step round length in clocks
//   roundValidO  one-cycle pulse when roundPeriodO updates
//   dirO         0 = forward (+1), 1 = reverse (-1)
//   trackingO    high while measuring (TRACK)
//   stallO       high while stalled (STALL)
//   overSpeedO   pulses with stepValidO when the period is below PERIOD_MIN
//   seqErrO      sticky illegal-transition flag
module m3_stepperiodmeasure #(
  parameter int                CNT_W      = 22,
  parameter int                ROUND_W    = 26,
  parameter logic [CNT_W-1:0]  PERIOD_MAX = 22'd4000000,
  parameter logic [CNT_W-1:0]  PERIOD_MIN = 22'd40
) (
  input  logic               clkI,
  input  logic               nRstI,
  input  logic [3:0]         stepI,
  input  logic               clrErrI,
  output logic [CNT_W-1:0]   stepPeriodO,
  output logic               stepValidO,
  output logic [ROUND_W-1:0] roundPeriodO,
  output logic               roundValidO,
  output logic               dirO,
  output logic               trackingO,
  output logic               stallO,
  output logic               overSpeedO,
  output logic               seqErrO
);

  typedef enum logic [1:0] {IDLE, SYNC, TRACK, STALL} state_t;

  state_t             state;
  state_t             stateNext;
  logic [3:0]         stepPrev;
  logic [CNT_W-1:0]   cnt;
  logic [ROUND_W-1:0] acc;
  logic [3:0]         stepCnt;

  logic               change;
  logic               isIdle;
  logic               stepLegal;
  logic               prevLegal;
  logic [3:0]         nextUp;
  logic [3:0]         nextDn;
  logic               fwd;
  logic               rev;
  logic               illegal;
  logic               stall;
  logic               matchDir;
  logic               oppDir;
  logic [ROUND_W-1:0] cntExt;

  // Transition decode against the previous sample. fwd/rev are only
  // meaningful from a valid step; from idle or 12..14 neither is asserted.
  always_comb begin
    change    = (stepI != stepPrev);
    isIdle    = (stepI == 4'hF);
    stepLegal = (stepI <= 4'd11);
    prevLegal = (stepPrev <= 4'd11);
    nextUp    = (stepPrev == 4'd11) ? 4'd0 : stepPrev + 4'd1;
    nextDn    = (stepPrev == 4'd0) ? 4'd11 : stepPrev - 4'd1;
    fwd       = change && prevLegal && stepLegal && (stepI == nextUp);
    rev       = change && prevLegal && stepLegal && (stepI == nextDn);
    illegal   = change && !isIdle && !fwd && !rev;
    stall     = !change && (cnt == PERIOD_MAX);
    matchDir  = dirO ? rev : fwd;
    oppDir    = dirO ? fwd : rev;
    cntExt    = ROUND_W'(cnt);
  end

  // State register
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: idle override first, then illegal, stall, measurement
  always_comb begin
    stateNext = state;
    if (isIdle) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (change && stepLegal) stateNext = SYNC;
        SYNC: begin
          if (illegal)          stateNext = SYNC;
          else if (fwd || rev)  stateNext = TRACK;
          else if (stall)       stateNext = STALL;
        end
        TRACK: begin
          if (illegal)          stateNext = SYNC;
          else if (stall)       stateNext = STALL;
        end
        STALL:   if (change && stepLegal) stateNext = SYNC;
        default: stateNext = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    trackingO = (state == TRACK);
    stallO    = (state == STALL);
  end

  // Sampling, step counter and sticky error flag
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      stepPrev <= 4'hF;
      cnt      <= '0;
      seqErrO  <= 1'b0;
    end else begin
      stepPrev <= stepI;
      if (change) begin
        cnt <= CNT_W'(1);
      end else if (cnt < PERIOD_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      // a new error beats a simultaneous clear
      if (illegal && (state == SYNC || state == TRACK)) begin
        seqErrO <= 1'b1;
      end else if (clrErrI) begin
        seqErrO <= 1'b0;
      end
    end
  end

  // Measurement datapath
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      acc          <= '0;
      stepCnt      <= '0;
      stepPeriodO  <= '0;
      stepValidO   <= 1'b0;
      roundPeriodO <= '0;
      roundValidO  <= 1'b0;
      dirO         <= 1'b0;
      overSpeedO   <= 1'b0;
    end else begin
      stepValidO  <= 1'b0;
      roundValidO <= 1'b0;
      overSpeedO  <= 1'b0;
      if (isIdle) begin
        acc     <= '0;
        stepCnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            acc     <= '0;
            stepCnt <= '0;
          end
          SYNC: begin
            // the step that just ended was only partially observed
            if (!illegal && (fwd || rev)) begin
              dirO    <= rev;
              acc     <= '0;
              stepCnt <= '0;
            end else if (stall) begin
              acc     <= '0;
              stepCnt <= '0;
            end
          end
          TRACK: begin
            if (illegal) begin
              // SYNC clears acc when it locks again
            end else if (stall) begin
              acc     <= '0;
              stepCnt <= '0;
            end else if (matchDir) begin
              stepPeriodO <= cnt;
              stepValidO  <= 1'b1;
              overSpeedO  <= (cnt < PERIOD_MIN);
              if (stepCnt == 4'd11) begin
                roundPeriodO <= acc + cntExt;
                roundValidO  <= 1'b1;
                acc          <= '0;
                stepCnt      <= '0;
              end else begin
                acc     <= acc + cntExt;
                stepCnt <= stepCnt + 4'd1;
              end
            end else if (oppDir) begin
              // reversal: restart the round in the new direction
              dirO    <= rev;
              acc     <= '0;
              stepCnt <= '0;
            end
          end
          STALL: begin
          end
          default: begin
            acc     <= '0;
            stepCnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/m3_stepperiodmeasure.md
Name: m3_stepPeriodMeasure

Overview:
- Observes the 4-bit commutation step index produced by the motor step generator. Step values 0..11 form one electrical round; 4'hF means idle.
- Measures the clocks spent in each step and the total clocks per 12-step round, and determines rotation direction.
- Flags stall, over-speed and sequence errors.
- Sits beside the generator on the 1 MHz clock domain. Feeds the speed display and the closed-loop speed check.

Parameters:
- PERIOD_MAX, 22'd4000000: per-step count ceiling. Reaching it declares a stall.
- PERIOD_MIN, 22'd40: a measured step period below this value flags over-speed.
- CNT_W, 22: width of the step counter and of stepPeriodO.
- ROUND_W, 26: width of the round accumulator and of roundPeriodO (12 × 4,000,000 fits).

Ports:
- clkI, input, 1: 1 MHz clock.
- nRstI, input, 1: asynchronous active-low reset.
- stepI, input, 4: step index from the generator (0..11 valid, 15 = idle).
- clrErrI, input, 1: clears sticky seqErrO.
- stepPeriodO, output, CNT_W: last measured step length in clocks.
- stepValidO, output, 1: one-cycle pulse when stepPeriodO updates.
- roundPeriodO, output, ROUND_W: last measured 12-step round length.
- roundValidO, output, 1: one-cycle pulse when roundPeriodO updates.
- dirO, output, 1: 0 = forward (+1), 1 = reverse (−1).
- trackingO, output, 1: high while state is TRACK.
- stallO, output, 1: high while state is STALL.
- overSpeedO, output, 1: one-cycle pulse together with stepValidO when the measured period is below PERIOD_MIN.
- seqErrO, output, 1: sticky illegal-transition flag.

Behaviour:
- Clock and reset: single clock clkI; asynchronous active-low reset nRstI.
- Reset values:
  - stepPrev = 4'hF, state = IDLE, cnt = 0, acc = 0, stepCnt = 0.
  - All outputs 0 (dirO = 0).
- Sampling: stepI is registered into stepPrev every cycle. change = (stepI != stepPrev), evaluated combinationally.
- Transition decode:
  - fwd = stepI == (stepPrev==11 ? 0 : stepPrev+1).
  - rev = stepI == (stepPrev==0 ? 11 : stepPrev−1).
  - Any other change with stepI in 0..11 is illegal.
  - stepI values 12..14 are illegal.
- Counter cnt:
  - Loads 1 on every change.
  - Otherwise increments, saturating at PERIOD_MAX.
- States:
  - IDLE: outputs held, acc and stepCnt = 0. On change to 0..11 → SYNC, cnt ← 1.
  - SYNC: discards the first partial step.
    - On fwd or rev: dirO ← rev, acc ← 0, stepCnt ← 0 → TRACK.
    - On illegal: seqErrO ← 1, stay in SYNC.
  - TRACK, on a change matching dirO:
    - stepPeriodO ← cnt; stepValidO pulses the next cycle.
    - overSpeedO pulses in the same cycle if cnt < PERIOD_MIN.
    - acc ← acc + cnt; stepCnt ← stepCnt + 1.
    - When stepCnt == 11: roundPeriodO ← acc + cnt, roundValidO pulses, acc ← 0, stepCnt ← 0.
  - TRACK, on a legal change in the opposite direction: dirO ← new direction, acc ← 0, stepCnt ← 0, stay in TRACK. No step or round output that cycle; this is a re-sync.
  - TRACK, on an illegal change: seqErrO ← 1 → SYNC.
  - STALL: entered from SYNC or TRACK when cnt == PERIOD_MAX with no change. On entry stallO = 1 and acc is cleared. Any change to 0..11 → SYNC and stallO = 0.
- Idle override: stepI == 15 from any state → IDLE next cycle. This clears stallO, trackingO, acc and stepCnt. stepPeriodO, roundPeriodO and dirO keep their last values.
- Event priority in one cycle: idle override > illegal transition > stall > normal measurement.
- seqErrO:
  - Cleared only by reset or clrErrI.
  - If clrErrI and a new error occur in the same cycle, set wins.
- Arithmetic: acc addition is ROUND_W wide and never overflows, because 12 × PERIOD_MAX < 2^26.
- Latency: stepValidO and roundValidO assert 1 cycle after the cycle in which stepI changes.

Test Plan:
- Forward rotation, 100 clocks per step, from idle (15 → 0 → 1 … 11 → 0 …):
  - first step is discarded; stepValidO at every subsequent step with stepPeriodO = 100;
  - roundValidO with roundPeriodO = 1200 after 12 measured steps;
  - dirO = 0, trackingO = 1.
- Reverse rotation (0 → 11 → 10 …) at 300 clocks per step: dirO = 1, stepPeriodO = 300, roundPeriodO = 3600.
- Forward at 100 clocks, then 5 → 4: no stepValidO on the reversal edge, dirO = 1, acc is cleared, and the next roundPeriodO comes from 12 reverse steps.
- Illegal jump 3 → 6:
  - seqErrO = 1 and state returns to SYNC;
  - a later clrErrI pulse clears seqErrO;
  - clrErrI in the same cycle as another illegal jump leaves seqErrO = 1.
- Step held for PERIOD_MAX (300 in the simulation build): stallO = 1 and trackingO = 0; the next legal change gives stallO = 0 and SYNC.
- Steps 30 clocks long: overSpeedO pulses with each stepValidO and stepPeriodO = 30. Drive stepI = 15 mid-round: IDLE, acc is cleared, stepPeriodO keeps 30. Assert nRstI mid-round: all outputs 0 immediately.
